uart_cmd_parser: RTL

Packet framer that sits directly downstream of the UART receiver. It consumes one received byte per `rx_valid` strobe and assembles framed command packets from the Pi: `SYNC, CMD, LEN, payload[LEN], CHK`. Accepted packets are presented to the command logic through a valid/ack handshake, with payload readable from an internal buffer. Malformed, timed-out or overrunning traffic is reported on an error strobe.

---
 rtl/uart_cmd_parser.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// Frames SYNC,CMD,LEN,payload,CHK byte packets from the UART receiver and holds each accepted one until acked.
// Optional inter-byte timeout is compiled in with `define UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       pkt_ack,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       pkt_valid,
  output logic [7:0]                 pkt_cmd,
  output logic [7:0]                 pkt_len,
  output logic                       err_pulse,
  output logic [1:0]                 err_code,
  output logic [7:0]                 leds
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam logic [1:0] E_TMO = 2'd0;
  localparam logic [1:0] E_CHK = 2'd1;
  localparam logic [1:0] E_LEN = 2'd2;
  localparam logic [1:0] E_OVR = 2'd3;

  logic [2:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] pkt_cmd_q, pkt_cmd_d;
  logic [7:0] pkt_len_q, pkt_len_d;
  logic [7:0] leds_q, leds_d;
  logic       err_pulse_q, err_pulse_d;
  logic [1:0] err_code_q, err_code_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       buf_we;
  logic [7:0] buf_q [MAX_LEN];

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  logic [31:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    pkt_valid_d = pkt_valid_q;
    pkt_cmd_d   = pkt_cmd_q;
    pkt_len_d   = pkt_len_q;
    leds_d      = leds_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: if (rx_data == SYNC_BYTE) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          if (rx_data > MAX_LEN_B) begin
            err_pulse_d = 1'b1;
            err_code_d  = E_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d = rx_data;
            chk_d = chk_q ^ rx_data;
            idx_d = 8'd0;
            state_d = (rx_data == 8'd0) ? S_CHK : S_DATA;
          end
        end
        S_DATA: begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          if (idx_q == len_q - 8'd1) state_d = S_CHK;
          else                       idx_d   = idx_q + 8'd1;
        end
        S_CHK: begin
          if (rx_data == chk_q) begin
            pkt_cmd_d   = cmd_q;
            pkt_len_d   = len_q;
            leds_d      = cmd_q;
            pkt_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            err_pulse_d = 1'b1;
            err_code_d  = E_CHK;
            state_d     = S_IDLE;
          end
        end
        S_HOLD: begin
          // The byte is dropped; the held packet must not be disturbed.
          err_pulse_d = 1'b1;
          err_code_d  = E_OVR;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_q == S_HOLD && pkt_ack) begin
      pkt_valid_d = 1'b0;
      state_d     = S_IDLE;
    end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    gap_d = 32'd0;
    if (state_q != S_IDLE && state_q != S_HOLD && !rx_valid) begin
      if (gap_q == 32'(TIMEOUT_CYCLES - 1)) begin
        err_pulse_d = 1'b1;
        err_code_d  = E_TMO;
        state_d     = S_IDLE;
      end else begin
        gap_d = gap_q + 32'd1;
      end
    end
`endif

    rd_data_d = 8'd0;
    if (32'(rd_addr) < 32'(MAX_LEN)) rd_data_d = buf_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      chk_q       <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_cmd_q   <= 8'd0;
      pkt_len_q   <= 8'd0;
      leds_q      <= 8'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      rd_data_q   <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'd0;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      gap_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_cmd_q   <= pkt_cmd_d;
      pkt_len_q   <= pkt_len_d;
      leds_q      <= leds_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      rd_data_q   <= rd_data_d;
      if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_cmd   = pkt_cmd_q;
  assign pkt_len   = pkt_len_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign leds      = leds_q;

endmodule
